// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub_pkg
//  Purpose  : Shared definitions for the bit-serial subtractor: FSM state
//             encoding and the default operand width.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/full_sub_cell.sv
`default_nettype none
// ============================================================================
//  Module   : full_sub_cell
//  Purpose  : One-bit full subtractor computing x - y - bin.
//  Ports    : x    - minuend bit
//             y    - subtrahend bit
//             bin  - borrow in
//             d    - difference bit
//             bout - borrow out
//  Revision : 1.0 - initial release
// ============================================================================
module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_xy;

    assign w_xy = x ^ y;
    assign d    = w_xy ^ bin;
    // Borrow when x=0,y=1, or when x==y and a borrow is already pending.
    assign bout = (~x & y) | (~w_xy & bin);

endmodule : full_sub_cell
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial unsigned subtractor. One bit per clock, LSB first,
//             through a single full-subtractor cell. Produces
//             diff = (a - b) mod 2^WIDTH and borrow = (a < b).
//  Ports    : clk    - clock, rising edge
//             rst    - asynchronous active-high reset
//             start  - operation request, accepted only when idle
//             a, b   - minuend / subtrahend, captured on the accepting edge
//             busy   - high while an operation is running or completing
//             done   - one-cycle completion pulse
//             diff   - registered difference, held until next completion
//             borrow - registered final borrow, held until next completion
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_res;
    logic               r_bflop;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;

    logic               w_d;
    logic               w_bout;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    full_sub_cell u_cell (
        .x    (r_opa[0]),
        .y    (r_opb[0]),
        .bin  (r_bflop),
        .d    (w_d),
        .bout (w_bout)
    );

    // The bit being processed on this edge is the final one.
    assign w_last     = (r_cnt == c_LAST);
    // Result fills from the MSB end so that after WIDTH shifts bit 0 is the LSB.
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_opa    <= '0;
            r_opb    <= '0;
            r_res    <= '0;
            r_bflop  <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_opa   <= a;
                        r_opb   <= b;
                        r_bflop <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_res   <= w_res_next;
                    r_opa   <= r_opa >> 1;
                    r_opb   <= r_opb >> 1;
                    r_bflop <= w_bout;
                    r_cnt   <= r_cnt + c_ONE;
                    // Publish on the edge that enters DONE, using the
                    // just-completed result rather than the stale register.
                    if (w_last) begin
                        r_diff   <= w_res_next;
                        r_borrow <= w_bout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule : serial_subtractor
`default_nettype wire
